// File: rtl/simplebfxp_unpack.sv
// Unpacks a run of equal-width bit fields from one 32-bit word and emits one field per beat.
// Latency: the first beat is valid in the cycle after the command is accepted, then one beat per cycle.
// Backpressure: out_ready low holds the beat and all state; a new command is taken only in IDLE.
module simplebfxp_unpack (
    input  logic        clock,
    input  logic        reset,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [31:0] cmd_word,
    input  logic [4:0]  cmd_start,
    input  logic [4:0]  cmd_len,
    input  logic [4:0]  cmd_count,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_data,
    output logic        out_last
);

    typedef enum logic {IDLE, RUN} state_t;

    state_t      state;
    state_t      state_nxt;
    logic [31:0] word_q;
    logic [4:0]  len_q;
    logic [4:0]  ptr_q;
    logic [4:0]  rem_q;
    logic        accept;
    logic        xfer;
    logic [63:0] word_dbl;
    logic [31:0] word_rot;
    logic [31:0] field_mask;

    assign cmd_ready = (state == IDLE) && !reset;
    assign out_valid = (state == RUN);
    assign accept    = cmd_valid && cmd_ready;
    assign xfer      = out_valid && out_ready;

    always_ff @(posedge clock) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (accept) state_nxt = RUN;
            RUN:  if (xfer && (rem_q == 5'd0)) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // len_q of 0 means a 32-bit field, so adding it leaves the pointer unchanged mod 32.
    always_ff @(posedge clock) begin
        if (reset) begin
            word_q <= '0;
            len_q  <= '0;
            ptr_q  <= '0;
            rem_q  <= '0;
        end else if (accept) begin
            word_q <= cmd_word;
            len_q  <= cmd_len;
            ptr_q  <= cmd_start;
            rem_q  <= cmd_count;
        end else if (xfer && (rem_q != 5'd0)) begin
            ptr_q <= ptr_q + len_q;
            rem_q <= rem_q - 5'd1;
        end
    end

    // Doubling the word turns a right rotation into a plain part-select.
    assign word_dbl   = {word_q, word_q};
    assign word_rot   = word_dbl[ptr_q +: 32];
    assign field_mask = (len_q == 5'd0) ? 32'hFFFF_FFFF : ((32'd1 << len_q) - 32'd1);

    assign out_data = (state == RUN) ? (word_rot & field_mask) : 32'd0;
    assign out_last = (state == RUN) && (rem_q == 5'd0);

endmodule
